// File: rtl/kmkz_exceptions_pkg.sv
// Shared CSR addresses, cause codes, mstatus bit positions and interrupt FSM states
// for the machine-mode trap block.
package kmkz_exceptions_pkg;

    localparam logic [11:0] CSR_ID_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ID_MIE     = 12'h304;
    localparam logic [11:0] CSR_ID_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_ID_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ID_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_ID_MIP     = 12'h344;

    localparam logic [3:0] EXC_IRQ_TIMER = 4'd7;
    localparam logic [3:0] EXC_IRQ_EXT   = 4'd11;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_ACK  = 2'd2
    } irq_state_e;

    function automatic logic [31:0] mstatus_word(input logic mpie, input logic mie);
        return {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
    endfunction

endpackage

// File: rtl/kmkz_exceptions_irq_sync.sv
// Reset-to-0 multi-flop synchronizer for the asynchronous external interrupt line.
module kmkz_irq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/kmkz_exceptions.sv
// Machine-mode trap/interrupt state: mstatus, mie, mip, mepc, mcause and interrupt request FSM.
// Define KMKZ_MTVEC_EN to add a writable mtvec register and the csr_mtvec_o port.
module kmkz_exceptions
    import kmkz_exceptions_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0008,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        d_is_csr_i,
    input  logic        d_is_mret_i,
    input  logic [11:0] d_csr_sel_i,
    input  logic [31:0] x_csr_write_value_i,
    input  logic        x_exception_i,
    input  logic [3:0]  x_exception_cause_i,
    input  logic [31:0] x_exception_pc_i,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    output logic        irq_o,
    input  logic        irq_ack_i,
    output logic [31:0] trap_vector_o,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o
`ifdef KMKZ_MTVEC_EN
    ,
    output logic [31:0] csr_mtvec_o
`endif
);

    logic        update;
    logic        exc_commit;
    logic        ack_take;
    logic        mret_commit;
    logic        csr_commit;

    logic        ext_irq_sync;
    logic        irq_ext_live;
    logic        irq_tim_live;
    logic        pending;
    logic [3:0]  pending_code;
    logic        latched_en_d;

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_meie_q, mie_meie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic [31:0] mepc_q, mepc_d;
    logic        mcause_int_q, mcause_int_d;
    logic [3:0]  mcause_code_q, mcause_code_d;
`ifdef KMKZ_MTVEC_EN
    logic [31:0] mtvec_q, mtvec_d;
`endif

    irq_state_e  state_q, state_d;
    logic [3:0]  irq_code_q, irq_code_d;

    kmkz_irq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (ext_irq_i),
        .sync_o  (ext_irq_sync)
    );

    // Only one source may modify trap state per cycle: exception > ack > MRET > CSR write.
    always_comb begin
        update      = !x_stall_i && !x_kill_i;
        exc_commit  = update && x_exception_i;
        ack_take    = (state_q == IRQ_REQ) && irq_ack_i && !exc_commit;
        mret_commit = update && d_is_mret_i && !exc_commit && !ack_take;
        csr_commit  = update && d_is_csr_i && !d_is_mret_i && !exc_commit && !ack_take;
    end

    always_comb begin
        irq_ext_live = ext_irq_sync && mie_meie_q;
        irq_tim_live = timer_irq_i && mie_mtie_q;
        pending      = mstatus_mie_q && (irq_ext_live || irq_tim_live);
        pending_code = irq_ext_live ? EXC_IRQ_EXT : EXC_IRQ_TIMER;
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mie_mtie_d     = mie_mtie_q;
        mepc_d         = mepc_q;
        mcause_int_d   = mcause_int_q;
        mcause_code_d  = mcause_code_q;
`ifdef KMKZ_MTVEC_EN
        mtvec_d        = mtvec_q;
`endif
        if (exc_commit) begin
            mepc_d         = x_exception_pc_i & 32'hFFFF_FFFE;
            mcause_int_d   = 1'b0;
            mcause_code_d  = x_exception_cause_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (ack_take) begin
            mepc_d         = x_exception_pc_i & 32'hFFFF_FFFE;
            mcause_int_d   = 1'b1;
            mcause_code_d  = irq_code_q;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_commit) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_commit) begin
            case (d_csr_sel_i)
                CSR_ID_MSTATUS: begin
                    mstatus_mie_d  = x_csr_write_value_i[MSTATUS_MIE];
                    mstatus_mpie_d = x_csr_write_value_i[MSTATUS_MPIE];
                end
                CSR_ID_MIE: begin
                    mie_meie_d = x_csr_write_value_i[11];
                    mie_mtie_d = x_csr_write_value_i[7];
                end
                CSR_ID_MEPC:   mepc_d = x_csr_write_value_i & 32'hFFFF_FFFE;
                CSR_ID_MCAUSE: begin
                    mcause_int_d  = x_csr_write_value_i[31];
                    mcause_code_d = x_csr_write_value_i[3:0];
                end
`ifdef KMKZ_MTVEC_EN
                CSR_ID_MTVEC:  mtvec_d = x_csr_write_value_i & 32'hFFFF_FFFC;
`else
                CSR_ID_MTVEC: ;
`endif
                CSR_ID_MIP: ;
                default: ;
            endcase
        end
    end

    // A request is withdrawn whenever the enables that justified it will not hold next
    // cycle; entry is also suppressed when a committed exception clears MIE this cycle.
    always_comb begin
        state_d      = state_q;
        irq_code_d   = irq_code_q;
        latched_en_d = (irq_code_q == EXC_IRQ_EXT) ? mie_meie_d : mie_mtie_d;
        case (state_q)
            IRQ_IDLE: begin
                if (pending && !x_stall_i && !exc_commit) begin
                    state_d    = IRQ_REQ;
                    irq_code_d = pending_code;
                end
            end
            IRQ_REQ: begin
                if (exc_commit) begin
                    state_d = IRQ_IDLE;
                end else if (ack_take) begin
                    state_d = IRQ_ACK;
                end else if (!mstatus_mie_d || !latched_en_d) begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_ACK:  state_d = IRQ_IDLE;
            default:  state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mepc_q         <= '0;
            mcause_int_q   <= 1'b0;
            mcause_code_q  <= '0;
`ifdef KMKZ_MTVEC_EN
            mtvec_q        <= TRAP_VECTOR & 32'hFFFF_FFFC;
`endif
            state_q        <= IRQ_IDLE;
            irq_code_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mie_mtie_q     <= mie_mtie_d;
            mepc_q         <= mepc_d;
            mcause_int_q   <= mcause_int_d;
            mcause_code_q  <= mcause_code_d;
`ifdef KMKZ_MTVEC_EN
            mtvec_q        <= mtvec_d;
`endif
            state_q        <= state_d;
            irq_code_q     <= irq_code_d;
        end
    end

    assign irq_o         = (state_q == IRQ_REQ);
    assign csr_mstatus_o = mstatus_word(mstatus_mpie_q, mstatus_mie_q);
    assign csr_mip_o     = {20'b0, ext_irq_sync, 3'b0, timer_irq_i, 7'b0};
    assign csr_mie_o     = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 7'b0};
    assign csr_mepc_o    = mepc_q;
    assign csr_mcause_o  = {mcause_int_q, 27'b0, mcause_code_q};
`ifdef KMKZ_MTVEC_EN
    assign csr_mtvec_o   = mtvec_q;
    assign trap_vector_o = mtvec_q;
`else
    assign trap_vector_o = TRAP_VECTOR & 32'hFFFF_FFFC;
`endif

endmodule

// File: doc/kmkz_exceptions.md
Name: kmkz_exceptions

Overview:
- Machine-mode trap/interrupt state block; sits directly downstream of the CSR unit.
- Owns mstatus, mie, mip, mepc, mcause (and optionally mtvec).
- Consumes the CSR unit's computed write value. Feeds current register values back to the CSR unit's read mux.
- Raises interrupt requests to the pipeline and supplies the trap vector and return PC.

Parameters:
- TRAP_VECTOR, 32'h00000008, fixed trap entry address (used when mtvec is compiled out; mtvec reset value otherwise).
- SYNC_STAGES, 2, synchronizer depth for ext_irq_i; legal values 2..3.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- x_stall_i  in  1  execute stage stalled; no architectural update
- x_kill_i  in  1  instruction in execute is killed
- d_is_csr_i  in  1  CSR instruction in execute
- d_is_mret_i  in  1  MRET in execute
- d_csr_sel_i  in  12  CSR address
- x_csr_write_value_i  in  32  write value from CSR unit
- x_exception_i  in  1  synchronous exception in execute
- x_exception_cause_i  in  4  exception code
- x_exception_pc_i  in  32  PC of faulting/interrupted instruction
- ext_irq_i  in  1  asynchronous external interrupt, level
- timer_irq_i  in  1  timer interrupt, level, clk_i-synchronous
- irq_o  out  1  interrupt request to pipeline
- irq_ack_i  in  1  pipeline takes interrupt this cycle
- trap_vector_o  out  32  trap target address
- csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o  out  32 each  CSR read values

Behaviour:
- Commit condition: update = !x_stall_i && !x_kill_i.
- Reset values: MIE=0, MPIE=0, mie=0, mepc=0, mcause=0, FSM=IDLE, irq_o=0, synchronizer flops=0.
- mstatus read value = {19'b0, 2'b11 (MPP, constant), 3'b0, MPIE, 3'b0, MIE, 3'b0}.
- mip read value: bit11=synchronized ext_irq, bit7=timer_irq_i, all other bits 0. mip is read-only.
- mie: only bits 11 and 7 are writable; all others read 0.
- mepc: bit0 always 0 (RV32IMC); writes mask bit0.
- mcause: bit31 = interrupt flag, bits[3:0] = code, others 0.
- CSR write: on update && d_is_csr_i, the register selected by d_csr_sel_i takes x_csr_write_value_i next cycle. Unknown selects are ignored.
- Exception: on update && x_exception_i:
  - mepc <= x_exception_pc_i
  - mcause <= {0, cause}
  - MPIE <= MIE; MIE <= 0
- MRET: on update && d_is_mret_i: MIE <= MPIE; MPIE <= 1.
- Same-cycle priority: exception > irq_ack_i > MRET > CSR write. Only one of these updates state per cycle.
- Pending interrupt = MIE && (mip & mie) != 0. External (code 11) has priority over timer (code 7).
- FSM IDLE:
  - pending && !x_stall_i -> REQ; latch the winning code.
- FSM REQ:
  - irq_o=1; the latched code is held even if the source deasserts.
  - irq_ack_i (and no exception this cycle) -> ACK. Effects: mepc <= x_exception_pc_i, mcause <= {1, code}, MPIE <= MIE, MIE <= 0.
  - A committed CSR write that clears MIE or the latched enable bit -> IDLE, with no trap taken.
  - A same-cycle exception wins; FSM -> IDLE.
- FSM ACK: one cycle, irq_o=0, then -> IDLE. Guarantees a one-cycle gap before any re-request.
- irq_ack_i outside REQ is ignored.
- trap_vector_o = TRAP_VECTOR, or mtvec when compiled in; bits[1:0] = 0.
- Reset mid-REQ: irq_o drops asynchronously with rst_i.

Optional Feature:
- Macro: KMKZ_MTVEC_EN.
- Defined: a writable mtvec register at CSR 0x305. Reset = TRAP_VECTOR; bits[1:0] forced 0. Read value exported on an extra port csr_mtvec_o [31:0]. trap_vector_o = mtvec.
- Undefined: no register and no port; trap_vector_o = TRAP_VECTOR constant; writes to 0x305 are ignored.

Decomposition:
- Shared defines file kmkz_defs.v holds:
  - CSR address constants, adding CSR_ID_MTVEC.
  - Cause codes: EXC_IRQ_TIMER=7, EXC_IRQ_EXT=11.
  - mstatus bit positions: MIE=3, MPIE=7.
  - FSM state encodings.
- One sub-module: kmkz_irq_sync, an SYNC_STAGES-deep reset-to-0 synchronizer for ext_irq_i.

Test Plan:
- Reset, then read all CSR outputs -> mstatus=0x00001800, mie=0, mepc=0, mcause=0, irq_o=0.
- CSR write mie=0xFFFFFFFF, then mstatus=0x8; raise timer_irq_i -> irq_o=1 one cycle later. Ack with pc=0x100 -> mepc=0x100, mcause=0x80000007, mstatus=0x1880, irq_o=0 for at least 1 cycle.
- Timer and ext_irq_i both asserted, enabled -> after SYNC_STAGES+1 cycles, mcause after ack = 0x8000000B.
- Exception cause 2 at pc=0x44 in the same cycle as irq_ack_i -> mcause=0x2, mepc=0x44, FSM IDLE. Interrupt re-requested after MRET restores MIE.
- In REQ, a committed CSR write of mstatus=0 -> irq_o=0 next cycle; mepc/mcause unchanged.
- With x_stall_i=1: CSR write, MRET and exception all ignored. Write mepc=0x203 -> reads 0x202. With KMKZ_MTVEC_EN, write 0x305=0x1003 -> trap_vector_o=0x1000.
